num_analyzer_scheduler: RTL and testbench

- Shares one number-property analyzer among NUM_REQ requesters.
- Round-robin arbitration, one request in flight at a time.
- Sequences the analyzer with a one-cycle go pulse, waits for done, and returns the tagged result to a single response port.
- Sits between the front-end request sources and the analyzer FSM.

---
 rtl/num_analyzer_scheduler_pkg.sv | 24 ++
 rtl/num_analyzer_scheduler_if.sv | 35 +++
 rtl/num_analyzer_scheduler_rr_arbiter.sv | 35 +++
 rtl/num_analyzer_scheduler.sv | 133 +++++++++++++
 tb/tb_num_analyzer_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/num_analyzer_scheduler_pkg.sv
// Shared types and constants for the number-analyzer scheduler slice.
// Optional WAIT timeout is enabled by defining NUM_ANALYZER_SCHED_TIMEOUT_EN.
package num_analyzer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam logic [1:0] OP_EVEN  = 2'd0;
  localparam logic [1:0] OP_ODD   = 2'd1;
  localparam logic [1:0] OP_PRIME = 2'd2;
  localparam logic [1:0] OP_POW2  = 2'd3;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/num_analyzer_scheduler_if.sv
// Request, analyzer and response signals of the scheduler, grouped as one bus.
// master = scheduler side, slave = requesters / analyzer / response sink.
interface num_analyzer_scheduler_if
  import num_analyzer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_number;
  logic [NUM_REQ*2-1:0]     req_op;
  logic                     an_go;
  logic [WIDTH-1:0]         an_number;
  logic [1:0]               an_op;
  logic                     an_done;
  logic                     an_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDX_W-1:0]         rsp_id;
  logic                     rsp_result;
  logic                     rsp_error;

  modport master (
    input  req_valid, req_number, req_op, an_done, an_result, rsp_ready,
    output req_ready, an_go, an_number, an_op, rsp_valid, rsp_id, rsp_result, rsp_error
  );

  modport slave (
    output req_valid, req_number, req_op, an_done, an_result, rsp_ready,
    input  req_ready, an_go, an_number, an_op, rsp_valid, rsp_id, rsp_result, rsp_error
  );
endinterface

// File: rtl/num_analyzer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after the
// pointer, searching upward with wrap.
module rr_arbiter
  import num_analyzer_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_any_valid
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_valid = 1'b0;
    w_found     = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_any_valid    = 1'b1;
        o_grant_idx    = IDX_W'(w_idx);
        o_grant[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/num_analyzer_scheduler.sv
// Shares one number-property analyzer among NUM_REQ requesters, one request in
// flight. Define NUM_ANALYZER_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
module num_analyzer_scheduler
  import num_analyzer_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  num_analyzer_scheduler_if.master bus,
  output logic                     busy,
  output logic [15:0]              done_count
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_id;
  logic [WIDTH-1:0]   r_number;
  logic [1:0]         r_op;
  logic               r_result;
  logic               r_go;
  logic               r_rsp_valid;
  logic [15:0]        r_done_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any_valid;
  logic               w_idle;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [WIDTH-1:0]   w_sel_number;
  logic [1:0]         w_sel_op;

`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_error;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req       (bus.req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_valid (w_any_valid)
  );

  // Accept is combinational so the grant and the operand latch share a cycle.
  assign w_idle        = (r_state == ST_IDLE) && !reset;
  assign bus.req_ready = w_idle ? w_grant : '0;
  assign w_sel_number  = bus.req_number[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_sel_op      = bus.req_op[int'(w_grant_idx)*2 +: 2];
  assign w_ptr_next    = IDX_W'(rr_next(int'(r_id), NUM_REQ));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_number     <= '0;
      r_op         <= '0;
      r_result     <= 1'b0;
      r_go         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_done_count <= '0;
`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
      r_wait_cnt   <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_number <= w_sel_number;
            r_op     <= w_sel_op;
            r_id     <= w_grant_idx;
            r_go     <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.an_done) begin
            r_result    <= bus.an_result;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESPOND;
`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
            r_error     <= 1'b0;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_result    <= 1'b0;
            r_error     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESPOND;
          end else begin
            r_wait_cnt  <= r_wait_cnt + 1'b1;
`endif
          end
        end
        ST_RESPOND: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_ptr        <= w_ptr_next;
            r_done_count <= r_done_count + 16'd1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.an_go      = r_go;
  assign bus.an_number  = r_number;
  assign bus.an_op      = r_op;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
  assign bus.rsp_error  = r_error;
`else
  assign bus.rsp_error  = 1'b0;
`endif
  assign busy       = (r_state != ST_IDLE);
  assign done_count = r_done_count;
endmodule

// File: tb/tb_num_analyzer_scheduler.sv
// Scoreboard bench for num_analyzer_scheduler: directed requests, an analyzer
// model, and a negedge monitor that checks grants, go pulses and responses.
module tb_num_analyzer_scheduler;
  import num_analyzer_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  typedef struct { int idx; logic [31:0] num; logic [1:0] op; } req_t;
  typedef struct { logic [31:0] num; logic [1:0] op; } go_t;
  typedef struct { int id; logic res; logic err; } rsp_t;

  logic        clock;
  logic        reset;
  logic        busy;
  logic [15:0] done_count;

  num_analyzer_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  num_analyzer_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  req_t pend[$];
  go_t  exp_go[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_total = 0;
  int   go_total = 0;
  int   exp_done = 0;
  int   an_lat = 3;
  bit   an_mute = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Analyzer model
  function automatic logic analyze(input logic [31:0] n, input logic [1:0] op);
    logic p;
    case (op)
      OP_EVEN: return ~n[0];
      OP_ODD:  return n[0];
      OP_POW2: return (n != 0) && ((n & (n - 1)) == 0);
      default: begin
        p = (n >= 2);
        for (int unsigned d = 2; d * d <= n && d < 1000; d++)
          if (n % d == 0) p = 0;
        return p;
      end
    endcase
  endfunction

  initial begin
    int cnt;
    logic [31:0] ln;
    logic [1:0]  lo;
    cnt = 0; ln = 0; lo = 0;
    bus.an_done = 0; bus.an_result = 0;
    forever begin
      @(negedge clock);
      bus.an_done = 0;
      if (reset) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.an_done   = 1;
          bus.an_result = analyze(ln, lo);
        end
      end
      if (bus.an_go && !reset && !an_mute) begin
        cnt = an_lat; ln = bus.an_number; lo = bus.an_op;
      end
    end
  end

  // Requester agent: each requester presents its oldest pending item.
  initial begin
    logic [NUM_REQ-1:0] hs;
    hs = '0;
    bus.req_valid = '0; bus.req_number = '0; bus.req_op = '0;
    forever begin
      @(negedge clock);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clock); #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          hs_total++;
          for (int k = 0; k < pend.size(); k++)
            if (pend[k].idx == i) begin pend.delete(k); break; end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_valid[i] = 0;
        for (int k = 0; k < pend.size(); k++)
          if (pend[k].idx == i) begin
            bus.req_valid[i] = 1;
            bus.req_number[i*WIDTH +: WIDTH] = pend[k].num;
            bus.req_op[i*2 +: 2] = pend[k].op;
            break;
          end
      end
    end
  end

  // Monitor
  initial begin
    go_t  g;
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.req_ready != 0) begin
          checks++;
          if (busy || !$onehot(bus.req_ready)) begin
            errors++;
            $display("FAIL req_ready: ready=%b busy=%0d required one-hot while idle", bus.req_ready, busy);
          end
        end
        if (bus.an_go) begin
          go_total++; checks++;
          if (exp_go.size() == 0) begin
            errors++; $display("FAIL an_go: unexpected go, number=%0h", bus.an_number);
          end else begin
            g = exp_go.pop_front();
            if (bus.an_number !== g.num || bus.an_op !== g.op) begin
              errors++;
              $display("FAIL an_go: number=%0h op=%0d required number=%0h op=%0d",
                       bus.an_number, bus.an_op, g.num, g.op);
            end
          end
        end
        if (bus.rsp_valid) begin
          checks++;
          if (exp_rsp.size() == 0) begin
            errors++; $display("FAIL rsp: unexpected response id=%0d", bus.rsp_id);
          end else begin
            e = bus.rsp_ready ? exp_rsp.pop_front() : exp_rsp[0];
            if (int'(bus.rsp_id) != e.id || bus.rsp_result !== e.res || bus.rsp_error !== e.err) begin
              errors++;
              $display("FAIL rsp: id=%0d result=%0d error=%0d required id=%0d result=%0d error=%0d",
                       bus.rsp_id, bus.rsp_result, bus.rsp_error, e.id, e.res, e.err);
            end
            if (bus.rsp_ready) begin
              checks++;
              if (int'(done_count) != exp_done) begin
                errors++;
                $display("FAIL done_count@rsp: got %0d required %0d", done_count, exp_done);
              end
              exp_done++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] num, input logic [1:0] op,
                      input logic res, input logic err, input bit want_rsp);
    req_t r; go_t g; rsp_t e;
    r.idx = idx; r.num = num; r.op = op;
    g.num = num; g.op = op;
    e.id = idx; e.res = res; e.err = err;
    pend.push_back(r);
    exp_go.push_back(g);
    if (want_rsp) exp_rsp.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1;
    pend.delete(); exp_go.delete(); exp_rsp.delete();
    step(); step();
    reset = 0;
    exp_done = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || pend.size() != 0) && n < budget) begin
      step(); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d responses outstanding, required 0", name, exp_rsp.size());
    end
    step();
  endtask

  task automatic wait_go(input string name, input int budget);
    int g0, n;
    g0 = go_total; n = 0;
    while (go_total == g0 && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL %s: no an_go within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int h0, g0, n;
    reset = 1;
    bus.rsp_ready = 1;
    repeat (3) step();
    reset = 0;

    // Reset then idle
    repeat (10) step();
    chk("idle busy", busy, 0);
    chk("idle rsp_valid", bus.rsp_valid, 0);
    chk("idle an_go", bus.an_go, 0);
    chk("idle req_ready", bus.req_ready, 0);
    chk("idle done_count", done_count, 0);
    chk("idle an_number", bus.an_number, 0);
    chk("idle rsp_id/result/error", {bus.rsp_id, bus.rsp_result, bus.rsp_error}, 0);

    // Single request on requester 2
    h0 = hs_total; g0 = go_total;
    push(2, 32'h0000_0006, OP_EVEN, 1, 0, 1);
    wait_drain("single", 50);
    chk("single ready pulses", hs_total - h0, 1);
    chk("single go pulses", go_total - g0, 1);
    chk("single done_count", done_count, 1);

    // Fairness: all four valid, expected grant order 0,1,2,3,0,1,2,3
    do_reset();
    push(0, 32'd7,  OP_ODD,   1, 0, 1);
    push(1, 32'd8,  OP_POW2,  1, 0, 1);
    push(2, 32'd9,  OP_PRIME, 0, 0, 1);
    push(3, 32'd10, OP_EVEN,  1, 0, 1);
    push(0, 32'd4,  OP_ODD,   0, 0, 1);
    push(1, 32'd12, OP_POW2,  0, 0, 1);
    push(2, 32'd13, OP_PRIME, 1, 0, 1);
    push(3, 32'd0,  OP_EVEN,  1, 0, 1);
    wait_drain("fairness", 200);
    chk("fairness done_count", done_count, 8);

    // Backpressure: response held while requester 0 waits
    bus.rsp_ready = 0;
    push(1, 32'hFFFF_FFFF, OP_ODD, 1, 0, 1);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin step(); n++; end
    chk("bp rsp_valid reached", bus.rsp_valid, 1);
    push(0, 32'd16, OP_POW2, 1, 0, 1);
    h0 = hs_total;
    repeat (5) step();
    chk("bp rsp_valid held", bus.rsp_valid, 1);
    chk("bp rsp_id held", bus.rsp_id, 1);
    chk("bp no req_ready", hs_total - h0, 0);
    bus.rsp_ready = 1;
    wait_drain("backpressure", 50);
    chk("bp done_count", done_count, 10);

    // Reset during WAIT
    an_lat = 20;
    push(3, 32'd5, OP_PRIME, 1, 0, 1);
    wait_go("rst go", 20);
    step(); step();
    chk("rst busy before", busy, 1);
    reset = 1;
    exp_rsp.delete();
    step();
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst done_count", done_count, 0);
    reset = 0;
    exp_done = 0;
    an_lat = 3;
    repeat (25) step();
    push(3, 32'd5, OP_PRIME, 1, 0, 1);
    wait_drain("after reset", 50);
    chk("after reset done_count", done_count, 1);

    // Analyzer never completes
    an_mute = 1;
`ifdef NUM_ANALYZER_SCHED_TIMEOUT_EN
    push(0, 32'd7, OP_ODD, 0, 1, 1);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.an_go && n < 20);
    chk("timeout go seen", bus.an_go, 1);
    repeat (8) @(negedge clock);
    chk("timeout not early", bus.rsp_valid, 0);
    @(negedge clock);
    chk("timeout rsp_valid", bus.rsp_valid, 1);
    chk("timeout rsp_error", bus.rsp_error, 1);
    step();
    wait_drain("timeout", 20);
    chk("timeout done_count", done_count, 2);
`else
    push(0, 32'd7, OP_ODD, 0, 0, 0);
    wait_go("hang go", 20);
    repeat (100) step();
    chk("hang rsp_valid", bus.rsp_valid, 0);
    chk("hang busy", busy, 1);
    chk("hang rsp_error", bus.rsp_error, 0);
    do_reset();
`endif
    an_mute = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
